// File: rtl/ofmap_serializer_if.sv
// Tile-control and pixel/ofmap stream signals for the ofmap serializer.
// master drives tiles and pixels; slave is the serializer itself.
interface ofmap_serializer_if #(
  parameter int OC0      = 4,
  parameter int DATA_WID = 32,
  parameter int CNT_WID  = 16
);
  logic [CNT_WID-1:0]      tile_pix;
  logic                    tile_start;
  logic                    busy;
  logic                    tile_done;
  logic [OC0*DATA_WID-1:0] pix_dat;
  logic                    pix_vld;
  logic                    pix_rdy;
  logic [DATA_WID-1:0]     ofmap_dat;
  logic                    ofmap_vld;
  logic                    ofmap_rdy;

  modport master (
    output tile_pix, tile_start, pix_dat, pix_vld, ofmap_rdy,
    input  busy, tile_done, pix_rdy, ofmap_dat, ofmap_vld
  );

  modport slave (
    input  tile_pix, tile_start, pix_dat, pix_vld, ofmap_rdy,
    output busy, tile_done, pix_rdy, ofmap_dat, ofmap_vld
  );
endinterface

// File: rtl/ofmap_serializer.sv
// Buffers whole pixel vectors in a small FIFO and emits them one channel word per cycle.
// Channel 0 appears the cycle after a pixel lands; pix_rdy depends only on registered state.
module ofmap_serializer #(
  parameter int OC0        = 4,
  parameter int DATA_WID   = 32,
  parameter int CNT_WID    = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ofmap_serializer_if.slave io
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int OC_W  = (OC0 > 1) ? $clog2(OC0) : 1;

  typedef logic [OC0-1:0][DATA_WID-1:0] pix_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_WID-1:0] tile_pix_q, tile_pix_d;
  logic [CNT_WID-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_WID-1:0] out_cnt_q, out_cnt_d;
  logic [OC_W-1:0]    oc_cnt_q, oc_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  pix_t               mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, pix_rdy_w, ofmap_vld_w;
  logic push, out_xfer, last_ch, pop;
  pix_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full   = (occ_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty  = (occ_q == '0);
  // Full FIFO keeps pix_rdy low even if the head pops this cycle: no ofmap_rdy bypass.
  assign pix_rdy_w   = (state_q == STREAM) && !fifo_full && (in_cnt_q < tile_pix_q);
  assign ofmap_vld_w = (state_q == STREAM) && !fifo_empty;
  assign head        = mem_q[rd_ptr_q];

  assign push     = io.pix_vld && pix_rdy_w;
  assign out_xfer = ofmap_vld_w && io.ofmap_rdy;
  assign last_ch  = (oc_cnt_q == OC_W'(OC0 - 1));
  assign pop      = out_xfer && last_ch;

  assign io.pix_rdy   = pix_rdy_w;
  assign io.ofmap_vld = ofmap_vld_w;
  assign io.ofmap_dat = ofmap_vld_w ? head[oc_cnt_q] : '0;
  assign io.busy      = (state_q != IDLE);
  assign io.tile_done = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    tile_pix_d = tile_pix_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    oc_cnt_d   = oc_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    case (state_q)
      IDLE: begin
        if (io.tile_start && (io.tile_pix != '0)) begin
          tile_pix_d = io.tile_pix;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          oc_cnt_d   = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          occ_d      = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (push) begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          in_cnt_d = in_cnt_q + CNT_WID'(1);
        end
        if (out_xfer) begin
          oc_cnt_d = last_ch ? '0 : oc_cnt_q + OC_W'(1);
          if (last_ch) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            out_cnt_d = out_cnt_q + CNT_WID'(1);
            if (out_cnt_q == tile_pix_q - CNT_WID'(1)) begin
              state_d = DONE;
            end
          end
        end
        case ({push, pop})
          2'b10:   occ_d = occ_q + OCC_W'(1);
          2'b01:   occ_d = occ_q - OCC_W'(1);
          default: occ_d = occ_q;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tile_pix_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      oc_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      tile_pix_q <= tile_pix_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      oc_cnt_q   <= oc_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= io.pix_dat;
    end
  end
endmodule

// File: tb/tb_ofmap_serializer.sv
// Directed bench for ofmap_serializer: basic tile, backpressure, FIFO full,
// zero-size start, mid-tile reset and signed data.
module tb_ofmap_serializer;
  localparam int OC0 = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int FD  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofmap_serializer_if #(.OC0(OC0), .DATA_WID(DW), .CNT_WID(CW)) io ();

  ofmap_serializer #(.OC0(OC0), .DATA_WID(DW), .CNT_WID(CW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [127:0] pix_mem [16];
  logic [31:0]  cap [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [127:0] p;
    p = pix_mem[w / OC0];
    return p[(w % OC0) * 32 +: 32];
  endfunction

  task automatic fill(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < OC0; c++) begin
        pix_mem[k][c*32 +: 32] = base + 32'(k * 16 + c);
      end
    end
  endtask

  task automatic start(input int n);
    io.tile_pix   = CW'(n);
    io.tile_start = 1'b1;
    @(posedge clk); #1;
    io.tile_start = 1'b0;
  endtask

  // Feeds pixels from sent_init on and collects words until stop_words or budget expires.
  task automatic stream(input int npix, input int mode, input int budget, input int sent_init,
                        input int stop_words, output int sent, output int got, output int cyc);
    logic [31:0] held;
    logic        hold_v;
    hold_v = 1'b0;
    held   = '0;
    sent   = sent_init;
    got    = 0;
    cyc    = 0;
    while (got < stop_words && cyc < budget) begin
      io.pix_vld   = (sent < npix);
      io.pix_dat   = pix_mem[(sent < npix) ? sent : 0];
      io.ofmap_rdy = (mode == 0) || (cyc % 2 == 0);
      #1;
      if (hold_v && io.ofmap_vld) chk("hold_stable", io.ofmap_dat, held);
      hold_v = io.ofmap_vld && !io.ofmap_rdy;
      held   = io.ofmap_dat;
      if (io.pix_vld && io.pix_rdy) sent++;
      if (io.ofmap_vld && io.ofmap_rdy) begin
        chk($sformatf("word%0d", got), io.ofmap_dat, exp_word(got));
        if (got < 64) cap[got] = io.ofmap_dat;
        got++;
      end
      chk("no_early_done", 32'(io.tile_done), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_budget", 32'(got), 32'(stop_words));
  endtask

  task automatic done_checks(input string tag);
    io.tile_start = 1'b0;
    io.pix_vld    = 1'b0;
    chk({tag, "_done_hi"}, 32'(io.tile_done), 32'd1);
    chk({tag, "_busy_done"}, 32'(io.busy), 32'd1);
    chk({tag, "_rdy_done"}, 32'(io.pix_rdy), 32'd0);
    chk({tag, "_vld_done"}, 32'(io.ofmap_vld), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_lo"}, 32'(io.tile_done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(io.busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(io.busy), 32'd0);
    chk({tag, "_pix_rdy"}, 32'(io.pix_rdy), 32'd0);
    chk({tag, "_ofmap_vld"}, 32'(io.ofmap_vld), 32'd0);
    chk({tag, "_tile_done"}, 32'(io.tile_done), 32'd0);
    chk({tag, "_ofmap_dat"}, io.ofmap_dat, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, cyc, acc;
    io.tile_pix   = '0;
    io.tile_start = 1'b0;
    io.pix_dat    = '0;
    io.pix_vld    = 1'b0;
    io.ofmap_rdy  = 1'b0;

    #12;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(io.busy), 32'd0);

    // Basic tile: 9 pixels, word = k*16+c, full throughput.
    fill(9, 32'h0);
    start(9);
    chk("basic_busy", 32'(io.busy), 32'd1);
    stream(9, 0, 200, 0, 36, sent, got, cyc);
    chk("basic_sent", 32'(sent), 32'd9);
    chk("basic_cycles", 32'(cyc), 32'd37);
    chk("basic_w0", cap[0], 32'h00);
    chk("basic_w3", cap[3], 32'h03);
    chk("basic_w4", cap[4], 32'h10);
    chk("basic_w35", cap[35], 32'h83);
    done_checks("basic");

    // Backpressure, with tile_start held high while the tile is active.
    fill(3, 32'h100);
    start(3);
    io.tile_pix   = CW'(1);
    io.tile_start = 1'b1;
    stream(3, 1, 200, 0, 12, sent, got, cyc);
    chk("bp_sent", 32'(sent), 32'd3);
    chk("bp_w5", cap[5], 32'h111);
    done_checks("bp");

    // FIFO full: no downstream ready, exactly two pixels fit.
    fill(3, 32'h200);
    start(3);
    io.pix_vld   = 1'b1;
    io.ofmap_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      io.pix_dat = pix_mem[(acc < 3) ? acc : 0];
      #1;
      if (io.pix_vld && io.pix_rdy) acc++;
      @(posedge clk); #1;
    end
    chk("full_accepted", 32'(acc), 32'd2);
    chk("full_pix_rdy", 32'(io.pix_rdy), 32'd0);
    chk("full_vld", 32'(io.ofmap_vld), 32'd1);
    chk("full_head", io.ofmap_dat, 32'h200);
    stream(3, 0, 200, 2, 12, sent, got, cyc);
    chk("full_sent", 32'(sent), 32'd3);
    chk("full_w7", cap[7], 32'h213);
    done_checks("full");

    // Zero-size start is ignored.
    io.tile_pix   = '0;
    io.tile_start = 1'b1;
    io.pix_vld    = 1'b1;
    io.ofmap_rdy  = 1'b1;
    @(posedge clk); #1;
    io.tile_start = 1'b0;
    chk("zero_busy", 32'(io.busy), 32'd0);
    chk("zero_done", 32'(io.tile_done), 32'd0);
    chk("zero_pix_rdy", 32'(io.pix_rdy), 32'd0);
    @(posedge clk); #1;
    chk("zero_done2", 32'(io.tile_done), 32'd0);
    chk("zero_vld2", 32'(io.ofmap_vld), 32'd0);

    // Reset after 5 words of a 4-pixel tile.
    fill(4, 32'h300);
    start(4);
    stream(4, 0, 200, 0, 5, sent, got, cyc);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    io.pix_vld   = 1'b1;
    io.ofmap_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_vld", 32'(io.ofmap_vld), 32'd0);
      chk("post_rst_rdy", 32'(io.pix_rdy), 32'd0);
    end
    pix_mem[0] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    start(1);
    stream(1, 0, 50, 0, 4, sent, got, cyc);
    chk("fresh_w0", cap[0], 32'hA0);
    chk("fresh_w3", cap[3], 32'hA3);
    done_checks("fresh");

    // Signed words pass unchanged.
    pix_mem[0] = {32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF6};
    start(1);
    stream(1, 0, 50, 0, 4, sent, got, cyc);
    chk("signed_w0", cap[0], 32'hFFFF_FFF6);
    chk("signed_w1", cap[1], 32'h8000_0000);
    chk("signed_w2", cap[2], 32'h7FFF_FFFF);
    done_checks("signed");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
